// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, oversampled by a cycle counter.
// Sticky status flags are cleared by a one-cycle rx_ack pulse.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_byte,
    output logic       rx_ready,
    output logic       frame_error,
    output logic       overrun
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_t;

    state_t        r_state, w_state_d;
    logic [CW-1:0] r_cnt, w_cnt_d;
    logic [2:0]    r_bit, w_bit_d;
    logic [7:0]    r_shift, w_shift_d;
    logic          r_rx_meta, r_rx_s;
    logic [7:0]    r_rx_byte;
    logic          r_rx_ready, r_frame_error, r_overrun;
    logic          w_frame_ok, w_frame_bad;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // FSM state, cycle counter, bit index and shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_bit   <= w_bit_d;
            r_shift <= w_shift_d;
        end
    end

    // Next-state logic; the counter is cleared at every bit boundary so it never wraps.
    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_bit_d     = r_bit;
        w_shift_d   = r_shift;
        w_frame_ok  = 1'b0;
        w_frame_bad = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!r_rx_s) begin
                    w_state_d = StStart;
                    w_cnt_d   = '0;
                end
            end
            StStart: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_d   = '0;
                    w_bit_d   = '0;
                    // A line that is high again at mid start bit was a glitch.
                    w_state_d = r_rx_s ? StIdle : StData;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StData: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_d   = '0;
                    w_shift_d = {r_rx_s, r_shift[7:1]};
                    w_bit_d   = r_bit + 1'b1;
                    if (r_bit == 3'd7) begin
                        w_state_d = StStop;
                    end
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StStop: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_d = '0;
                    if (r_rx_s) begin
                        w_frame_ok = 1'b1;
                        w_state_d  = StIdle;
                    end else begin
                        w_frame_bad = 1'b1;
                        w_state_d   = StBreak;
                    end
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StBreak: begin
                // Wait for the line to go idle so a held-low line is not seen as a start.
                if (r_rx_s) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Output byte and sticky flags; a completing event wins over rx_ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_byte     <= 8'h00;
            r_rx_ready    <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_frame_ok) begin
                r_rx_byte  <= r_shift;
                r_rx_ready <= 1'b1;
            end else if (rx_ack) begin
                r_rx_ready <= 1'b0;
            end

            if (w_frame_ok && r_rx_ready && !rx_ack) begin
                r_overrun <= 1'b1;
            end else if (rx_ack) begin
                r_overrun <= 1'b0;
            end

            if (w_frame_bad) begin
                r_frame_error <= 1'b1;
            end else if (rx_ack) begin
                r_frame_error <= 1'b0;
            end
        end
    end

    assign rx_byte     = r_rx_byte;
    assign rx_ready    = r_rx_ready;
    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with CLKS_PER_BIT = 8.
module tb_uart_rx;

    localparam int unsigned CPB  = 8;
    localparam int          DONE = 2 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_byte;
    logic       rx_ready, frame_error, overrun;

    int checks = 0;
    int errors = 0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_ack     (rx_ack),
        .rx_byte    (rx_byte),
        .rx_ready   (rx_ready),
        .frame_error(frame_error),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       ack_edge;
        logic       ack_after;
        logic [7:0] exp_byte;
        logic       exp_ready;
        logic       exp_fe;
        logic       exp_ovr;
    } vec_t;

    vec_t tbl[9];

    // Reference model state: flag rules applied per completed frame / ack pulse.
    logic [7:0] m_byte;
    logic       m_ready, m_fe, m_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] b, input logic r,
                             input logic f, input logic o);
        check($sformatf("%s rx_byte", tag), 32'(rx_byte), 32'(b));
        check($sformatf("%s rx_ready", tag), 32'(rx_ready), 32'(r));
        check($sformatf("%s frame_error", tag), 32'(frame_error), 32'(f));
        check($sformatf("%s overrun", tag), 32'(overrun), 32'(o));
    endtask

    // Drive a 10-bit serial word LSB first, one bit per CPB cycles; starts on a negedge.
    task automatic drive_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) begin
            rx = w[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop);
        drive_word({stop, d, 1'b0});
        rx = 1'b1;
    endtask

    // Raise rx_ack for exactly the clock edge on which the frame completes.
    task automatic ack_at_done();
        repeat (DONE) @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input logic ack_edge,
                        input int gap);
        if (ack_edge) begin
            fork
                drive_frame(d, stop);
                ack_at_done();
            join
        end else begin
            drive_frame(d, stop);
        end
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rx     = 1'b1;
        rx_ack = 1'b0;
        rst    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        m_byte  = 8'h00;
        m_ready = 1'b0;
        m_fe    = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop, input logic ack_edge);
        if (stop) begin
            if (ack_edge) begin
                m_ovr = 1'b0;
                m_fe  = 1'b0;
            end else if (m_ready) begin
                m_ovr = 1'b1;
            end
            m_ready = 1'b1;
            m_byte  = d;
        end else begin
            m_fe = 1'b1;
            if (ack_edge) begin
                m_ready = 1'b0;
                m_ovr   = 1'b0;
            end
        end
    endtask

    task automatic model_ack();
        m_ready = 1'b0;
        m_fe    = 1'b0;
        m_ovr   = 1'b0;
    endtask

    initial begin
        int         lat;
        logic       seen;
        logic [7:0] d;
        logic       stop;
        int         mode;

        tbl[0] = '{8'h55, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'hA3, 1'b1, 1'b0, 1'b0, 8'hA3, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h0F, 1'b1, 1'b0, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{8'hC4, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{8'h12, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{8'h99, 1'b0, 1'b1, 1'b0, 8'h12, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};

        // Reset values
        repeat (3) @(negedge clk);
        check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 0x55 and rx_ready latency from the start edge
        lat  = -1;
        seen = 1'b0;
        fork
            drive_frame(8'h55, 1'b1);
            begin
                for (int c = 0; c < 200 && !seen; c++) begin
                    @(posedge clk);
                    #1;
                    if (rx_ready) begin
                        seen = 1'b1;
                        lat  = c;
                    end
                end
            end
        join
        repeat (4) @(negedge clk);
        checks++;
        if (!seen || lat < DONE - 1 || lat > DONE + 1) begin
            errors++;
            $display("FAIL rx_ready latency: got %0d cycles expected %0d +-1", lat, DONE);
        end
        check_all("first 0x55", 8'h55, 1'b1, 1'b0, 1'b0);

        // Table-driven frame sequence
        do_reset();
        foreach (tbl[i]) begin
            send(tbl[i].data, tbl[i].stop, tbl[i].ack_edge, 4);
            if (tbl[i].ack_after) pulse_ack();
            check_all($sformatf("vec%0d", i), tbl[i].exp_byte, tbl[i].exp_ready,
                      tbl[i].exp_fe, tbl[i].exp_ovr);
        end

        // Bad stop bit then line held low: no start until the line returns high
        do_reset();
        drive_word({1'b0, 8'hC4, 1'b0});
        rx = 1'b0;
        repeat (40) @(negedge clk);
        check("break fe", 32'(frame_error), 32'd1);
        check("break ready", 32'(rx_ready), 32'd0);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        check("after break ready", 32'(rx_ready), 32'd0);
        send(8'h12, 1'b1, 1'b0, 4);
        check_all("post-break 0x12", 8'h12, 1'b1, 1'b1, 1'b0);

        // Short low glitch on idle line is rejected
        do_reset();
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check_all("glitch", 8'h00, 1'b0, 1'b0, 1'b0);
        send(8'hB6, 1'b1, 1'b0, 4);
        check_all("post-glitch 0xB6", 8'hB6, 1'b1, 1'b0, 1'b0);

        // Reset during the data bits of 0x7E
        do_reset();
        fork
            drive_frame(8'h7E, 1'b1);
            begin
                repeat (30) @(negedge clk);
                rst = 1'b0;
                #1;
                check_all("mid-frame reset", 8'h00, 1'b0, 1'b0, 1'b0);
            end
        join
        repeat (4) @(negedge clk);
        check_all("held reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_all("after release", 8'h00, 1'b0, 1'b0, 1'b0);
        send(8'h81, 1'b1, 1'b0, 4);
        check_all("post-reset 0x81", 8'h81, 1'b1, 1'b0, 1'b0);

        // Randomized frames against the reference model
        do_reset();
        for (int n = 0; n < 30; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            mode = $urandom_range(0, 2);
            send(d, stop, mode == 1, $urandom_range(4, 12));
            model_frame(d, stop, mode == 1);
            if (mode == 2) begin
                pulse_ack();
                model_ack();
            end
            check_all($sformatf("rand%0d", n), m_byte, m_ready, m_fe, m_ovr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, clk cycles per serial bit; legal values are even and at least 4.
REQ-002 Port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port rst  input  1  reset, asynchronous assert, active-low (0 = reset), released synchronously to clk by the integrator.
REQ-004 Port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 Port rx_ack  input  1  consumer acknowledge; a 1-cycle pulse clears rx_ready, frame_error and overrun.
REQ-006 Port rx_byte  output  8  last correctly framed byte; stable while rx_ready=1.
REQ-007 Port rx_ready  output  1  sticky flag, a received byte is available.
REQ-008 Port frame_error  output  1  sticky flag, stop bit sampled low.
REQ-009 Port overrun  output  1  sticky flag, a byte completed while rx_ready=1 and no rx_ack in the same cycle.

Function
REQ-010 rx shall pass through a 2-flop synchronizer (reset value 1); all logic uses the synchronized value rx_s.
REQ-011 FSM states shall be IDLE, START, DATA, STOP, BREAK; the reset state is IDLE.
REQ-012 In IDLE, rx_s=0 shall move to START with the bit counter cleared.
REQ-013 START shall count CLKS_PER_BIT/2 cycles and then sample rx_s; 0 -> DATA with the counter cleared, 1 -> IDLE (glitch rejected, no flag change).
REQ-014 DATA shall sample rx_s every CLKS_PER_BIT cycles into the shift register, LSB first, and move to STOP after the 8th sample.
REQ-015 STOP shall sample rx_s after CLKS_PER_BIT cycles; 1 -> valid frame and IDLE, 0 -> frame_error<=1, byte discarded, move to BREAK.
REQ-016 BREAK shall stay until rx_s=1, then move to IDLE; no new start is detected while in BREAK.
REQ-017 On a valid frame, rx_byte<=shift register and rx_ready<=1 on the same edge.
REQ-018 On a valid frame while rx_ready=1 and rx_ack=0, overrun<=1 and rx_byte is overwritten with the new byte.
REQ-019 On a valid frame coinciding with rx_ack=1, rx_ready stays 1 with the new byte and overrun is not set.
REQ-020 rx_ack with no completing frame shall clear rx_ready, frame_error and overrun on the next edge; rx_ack while rx_ready=0 is harmless.
REQ-021 A frame_error coinciding with rx_ack shall leave frame_error=1 (the set wins over the clear).
REQ-022 rx_ready shall rise within 2+CLKS_PER_BIT/2+9*CLKS_PER_BIT ±1 cycles of the rx falling edge that starts the frame.
REQ-023 The cycle counter width shall be $clog2(CLKS_PER_BIT) bits and the counter shall never wrap mid-bit.

Reset
REQ-024 rst=0 shall, asynchronously: state=IDLE, counters=0, synchronizer flops=1, rx_byte=8'h00, rx_ready=0, frame_error=0, overrun=0.
REQ-025 Reset asserted mid-frame shall abort the frame with no flag set; after release, a new frame is received only after a fresh falling edge.

Verification (CLKS_PER_BIT=8)
REQ-026 Send 0x55 with a valid stop bit -> rx_byte=8'h55, rx_ready=1 at 78±1 cycles after the start edge, frame_error=0.
REQ-027 Send 0xA3, then 0x0F with no rx_ack -> rx_byte=8'h0F, rx_ready=1, overrun=1; then rx_ack -> all three flags are 0 on the next cycle.
REQ-028 Send 0xC4 with the stop bit low, then hold rx low for 40 cycles -> frame_error=1, rx_ready=0, no start detected until rx returns high; the next 0x12 is received correctly.
REQ-029 Drive a 2-cycle low glitch on idle rx -> FSM returns to IDLE, rx_ready=0, frame_error=0.
REQ-030 Assert rst during DATA of 0x7E -> all outputs at reset values; the following frame 0x81 gives rx_byte=8'h81.
REQ-031 Pulse rx_ack on the exact edge that completes frame 0x3C while rx_ready=1 -> rx_byte=8'h3C, rx_ready=1, overrun=0.
